// File: rtl/vend_txn_if.sv
// Vending transaction bus: coin acceptor events, actuator handshakes, status.
// master = transaction controller, slave = acceptor/actuator side.
interface vend_txn_if #(
  parameter int CREDIT_W = 6
);
  logic                coin_valid;
  logic                coin_type;
  logic                cancel;
  logic                disp_req;
  logic                disp_ack;
  logic                chg_req;
  logic                chg_ack;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic                coin_reject;
  logic                vend_done;

  modport master (
    input  coin_valid, coin_type, cancel,
    input  disp_ack, chg_ack,
    output disp_req, chg_req, credit,
    output busy, coin_reject, vend_done
  );

  modport slave (
    output coin_valid, coin_type, cancel,
    output disp_ack, chg_ack,
    input  disp_req, chg_req, credit,
    input  busy, coin_reject, vend_done
  );
endinterface

// File: rtl/vend_txn_ctrl.sv
// Vending transaction controller: credit accumulation, dispense, change.
// One transaction at a time; coins offered while busy are rejected.
module vend_txn_ctrl #(
  parameter int PRICE    = 15,
  parameter int CREDIT_W = 6,
  parameter int TIMEOUT  = 1000,
  parameter int TMO_W    = 10
) (
  input  logic clock,
  input  logic rst,
  vend_txn_if.master bus
);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] COLLECT  = 2'd1;
  localparam logic [1:0] DISPENSE = 2'd2;
  localparam logic [1:0] CHANGE   = 2'd3;

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] FIVE    = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] TEN     = CREDIT_W'(10);
  localparam logic [TMO_W-1:0]    TMO_END = TMO_W'(TIMEOUT - 1);

  logic [1:0]          state;
  logic [CREDIT_W-1:0] credit;
  logic [TMO_W-1:0]    tmo;
  logic                disp_req;
  logic                chg_req;
  logic                busy;
  logic                coin_reject;
  logic                vend_done;

  logic [CREDIT_W-1:0] v;
  logic [CREDIT_W-1:0] nc;
  logic                quit;

  assign v  = bus.coin_type ? TEN : FIVE;
  assign nc = bus.coin_valid ? credit + v : credit;

  // Explicit cancel wins; an idle timeout acts as cancel only with no coin.
  assign quit = bus.cancel ||
                (!bus.coin_valid && tmo == TMO_END);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      tmo         <= '0;
      disp_req    <= 1'b0;
      chg_req     <= 1'b0;
      busy        <= 1'b0;
      coin_reject <= 1'b0;
      vend_done   <= 1'b0;
    end else begin
      coin_reject <= 1'b0;
      vend_done   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.coin_valid) begin
            credit <= v;
            tmo    <= '0;
            state  <= COLLECT;
          end
        end
        COLLECT: begin
          if (quit) begin
            coin_reject <= bus.coin_valid;
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (bus.coin_valid) begin
            if (nc >= PRICE_C) begin
              credit   <= nc - PRICE_C;
              state    <= DISPENSE;
              disp_req <= 1'b1;
              busy     <= 1'b1;
            end else begin
              credit <= nc;
              tmo    <= '0;
            end
          end else begin
            tmo <= tmo + 1'b1;
          end
        end
        DISPENSE: begin
          coin_reject <= bus.coin_valid;
          if (bus.disp_ack) begin
            disp_req  <= 1'b0;
            vend_done <= 1'b1;
            if (credit != '0) begin
              state   <= CHANGE;
              chg_req <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        CHANGE: begin
          coin_reject <= bus.coin_valid;
          if (bus.chg_ack) begin
            credit <= credit - FIVE;
            if (credit == FIVE) begin
              chg_req <= 1'b0;
              busy    <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.disp_req    = disp_req;
  assign bus.chg_req     = chg_req;
  assign bus.credit      = credit;
  assign bus.busy        = busy;
  assign bus.coin_reject = coin_reject;
  assign bus.vend_done   = vend_done;
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl: purchases, change, cancel,
// rejects, timeout refund and async reset.
module tb_vend_txn_ctrl;
  localparam int CW = 6;
  localparam int TO = 8;

  logic clock;
  logic rst;
  int   checks;
  int   errors;

  vend_txn_if #(.CREDIT_W(CW)) bus ();

  vend_txn_ctrl #(
    .PRICE(15),
    .CREDIT_W(CW),
    .TIMEOUT(TO),
    .TMO_W(4)
  ) dut (
    .clock(clock),
    .rst(rst),
    .bus(bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic coin(input logic t);
    bus.coin_valid = 1'b1;
    bus.coin_type  = t;
    tick();
    bus.coin_valid = 1'b0;
    bus.coin_type  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst            = 1'b1;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 1'b0;
    bus.cancel     = 1'b0;
    bus.disp_ack   = 1'b0;
    bus.chg_ack    = 1'b0;
    #12;
    chk("rst_credit", 32'(bus.credit), 0);
    chk("rst_disp", 32'(bus.disp_req), 0);
    chk("rst_chg", 32'(bus.chg_req), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_rej", 32'(bus.coin_reject), 0);
    chk("rst_done", 32'(bus.vend_done), 0);
    rst = 1'b0;
    tick();

    // three 5-unit coins, spaced
    coin(1'b0);
    chk("t1_c5", 32'(bus.credit), 5);
    tick();
    coin(1'b0);
    chk("t1_c10", 32'(bus.credit), 10);
    chk("t1_nodisp", 32'(bus.disp_req), 0);
    tick();
    coin(1'b0);
    chk("t1_disp", 32'(bus.disp_req), 1);
    chk("t1_c0", 32'(bus.credit), 0);
    chk("t1_busy", 32'(bus.busy), 1);
    tick();
    chk("t1_hold", 32'(bus.disp_req), 1);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    chk("t1_drop", 32'(bus.disp_req), 0);
    chk("t1_done", 32'(bus.vend_done), 1);
    chk("t1_idle", 32'(bus.busy), 0);
    chk("t1_nochg", 32'(bus.chg_req), 0);
    tick();
    chk("t1_pulse", 32'(bus.vend_done), 0);

    // two 10-unit coins -> dispense plus one coin change
    coin(1'b1);
    chk("t2_c10", 32'(bus.credit), 10);
    coin(1'b1);
    chk("t2_disp", 32'(bus.disp_req), 1);
    chk("t2_c5", 32'(bus.credit), 5);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    chk("t2_done", 32'(bus.vend_done), 1);
    chk("t2_chg", 32'(bus.chg_req), 1);
    chk("t2_busy", 32'(bus.busy), 1);
    chk("t2_credit", 32'(bus.credit), 5);
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    chk("t2_c0", 32'(bus.credit), 0);
    chk("t2_nochg", 32'(bus.chg_req), 0);
    chk("t2_idle", 32'(bus.busy), 0);

    // 10-unit coin then cancel -> refund two coins
    coin(1'b1);
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    chk("t3_chg", 32'(bus.chg_req), 1);
    chk("t3_c10", 32'(bus.credit), 10);
    chk("t3_busy", 32'(bus.busy), 1);
    bus.chg_ack = 1'b1;
    tick();
    chk("t3_c5", 32'(bus.credit), 5);
    chk("t3_chg1", 32'(bus.chg_req), 1);
    tick();
    bus.chg_ack = 1'b0;
    chk("t3_c0", 32'(bus.credit), 0);
    chk("t3_nochg", 32'(bus.chg_req), 0);
    chk("t3_idle", 32'(bus.busy), 0);
    chk("t3_nodone", 32'(bus.vend_done), 0);

    // coin offered during DISPENSE is rejected
    coin(1'b1);
    coin(1'b1);
    coin(1'b0);
    chk("t4_rej", 32'(bus.coin_reject), 1);
    chk("t4_credit", 32'(bus.credit), 5);
    chk("t4_disp", 32'(bus.disp_req), 1);
    tick();
    chk("t4_rejpulse", 32'(bus.coin_reject), 0);
    bus.disp_ack = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    bus.chg_ack  = 1'b1;
    tick();
    bus.chg_ack  = 1'b0;
    chk("t4_idle", 32'(bus.busy), 0);

    // cancel and coin together in COLLECT
    coin(1'b0);
    bus.cancel     = 1'b1;
    bus.coin_valid = 1'b1;
    bus.coin_type  = 1'b1;
    tick();
    bus.cancel     = 1'b0;
    bus.coin_valid = 1'b0;
    bus.coin_type  = 1'b0;
    chk("t4_crej", 32'(bus.coin_reject), 1);
    chk("t4_ccredit", 32'(bus.credit), 5);
    chk("t4_cchg", 32'(bus.chg_req), 1);
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    chk("t4_cc0", 32'(bus.credit), 0);

    // stray acks while idle are ignored
    bus.disp_ack = 1'b1;
    bus.chg_ack  = 1'b1;
    tick();
    bus.disp_ack = 1'b0;
    bus.chg_ack  = 1'b0;
    chk("ack_done", 32'(bus.vend_done), 0);
    chk("ack_busy", 32'(bus.busy), 0);
    chk("ack_credit", 32'(bus.credit), 0);

    // timeout refund after TO idle cycles in COLLECT
    coin(1'b0);
    for (int i = 0; i < TO - 1; i++) tick();
    chk("t5_early", 32'(bus.chg_req), 0);
    chk("t5_ecredit", 32'(bus.credit), 5);
    tick();
    chk("t5_chg", 32'(bus.chg_req), 1);
    chk("t5_credit", 32'(bus.credit), 5);
    chk("t5_busy", 32'(bus.busy), 1);
    bus.chg_ack = 1'b1;
    tick();
    bus.chg_ack = 1'b0;
    chk("t5_idle", 32'(bus.chg_req), 0);
    chk("t5_c0", 32'(bus.credit), 0);

    // asynchronous reset while dispensing
    coin(1'b1);
    coin(1'b1);
    chk("t6_disp", 32'(bus.disp_req), 1);
    chk("t6_c5", 32'(bus.credit), 5);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rdisp", 32'(bus.disp_req), 0);
    chk("t6_rcredit", 32'(bus.credit), 0);
    chk("t6_rbusy", 32'(bus.busy), 0);
    #2;
    rst = 1'b0;
    tick();
    coin(1'b0);
    chk("t6_after", 32'(bus.credit), 5);
    chk("t6_abusy", 32'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
